// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Latency: none (declarations only).
// Backpressure: none.
package regfile_pkg;

    // Clear sequencer states: IDLE lets traffic through, CLEAR walks the array to zero
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_AW     = 5;
    localparam int DEF_NUM_RD = 2;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: steps an address through every entry once, strobing a zero write.
// Latency: clr is sampled on the rising edge; the walk takes exactly 2**AW cycles.
// Backpressure: busy stays high for the whole walk; clr is ignored until it ends.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic [AW-1:0] clr_addr,
    output logic          clr_stb
);

    clr_state_e    state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;

    // Two-state walk; reset drops straight into CLEAR so the array is scrubbed after power-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // The last entry ends the walk; the counter is left parked, never wrapped
                    if (cnt_q == {AW{1'b1}}) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign clr_addr = cnt_q;
    assign clr_stb  = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Register file with two prioritized write ports, NUM_RD combinational read ports and a self-clear walk.
// Latency: reads are zero-latency; writes are visible next cycle (same cycle when BYPASS=1).
// Backpressure: while busy, writes are dropped and every read port returns zero.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AW       = DEF_AW,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we0,
    input  logic [AW-1:0]           wa0,
    input  logic [WIDTH-1:0]        wd0,
    input  logic                    we1,
    input  logic [AW-1:0]           wa1,
    input  logic [WIDTH-1:0]        wd1,
    input  logic [NUM_RD*AW-1:0]    ra,
    output logic [NUM_RD*WIDTH-1:0] rd,
    input  logic                    clr,
    output logic                    busy
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    clr_addr;
    logic             clr_stb;
    logic             wr0_ok;
    logic             wr1_ok;

    regfile_clr_seq #(
        .AW (AW)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_stb  (clr_stb)
    );

    // A write is live only outside a clear walk and, with a hardwired zero entry, not aimed at entry 0
    assign wr0_ok = we0 && !busy && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1_ok = we1 && !busy && !((ZERO_REG != 0) && (wa1 == '0));

    // Storage is not reset; the clear walk scrubs it. Port 1 is written last so it wins a collision
    always_ff @(posedge clk) begin
        if (clr_stb) begin
            mem_q[clr_addr] <= '0;
        end else begin
            if (wr0_ok) mem_q[wa0] <= wd0;
            if (wr1_ok) mem_q[wa1] <= wd1;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]    ra_g;
        logic [WIDTH-1:0] rd_g;

        assign ra_g = ra[g*AW +: AW];

        // Read mux: stored value, optionally overridden by a same-cycle write, then forced to zero
        always_comb begin
            rd_g = mem_q[ra_g];
            if (BYPASS != 0) begin
                if (wr1_ok && (wa1 == ra_g)) begin
                    rd_g = wd1;
                end else if (wr0_ok && (wa0 == ra_g)) begin
                    rd_g = wd0;
                end
            end
            if (busy || ((ZERO_REG != 0) && (ra_g == '0))) begin
                rd_g = '0;
            end
        end

        assign rd[g*WIDTH +: WIDTH] = rd_g;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a plain instance and a bypass instance share stimulus against one array model.
// Latency: inputs change on the falling edge; outputs are compared 1 time unit later.
// Backpressure: the model tracks clear walks as a count of remaining busy cycles.
module tb_regfile_mp;

    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we0, we1, clr;
    logic [AW-1:0] wa0, wa1;
    logic [W-1:0]  wd0, wd1;
    logic [NR*AW-1:0] ra;
    logic [NR*W-1:0]  rd_a, rd_b;
    logic          busy_a, busy_b;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(W), .AW(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_a), .clr(clr), .busy(busy_a)
    );

    regfile_mp #(.WIDTH(W), .AW(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_b), .clr(clr), .busy(busy_b)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [W-1:0] ref_mem [DEPTH];
    int          clear_left;
    bit          last_busy;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected read: zero while clearing or at entry 0, else newest write (bypass only) or stored value
    function automatic logic [W-1:0] exp_rd(input bit byp, input logic [AW-1:0] a);
        if (clear_left > 0) return '0;
        if (a == '0) return '0;
        if (byp && we1 && (wa1 == a)) return wd1;
        if (byp && we0 && (wa0 == a)) return wd0;
        return ref_mem[a];
    endfunction

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic set_idle();
        we0 = 1'b0; we1 = 1'b0; clr = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    endtask

    task automatic set_ra(input int a0, input int a1);
        ra = {AW'(a1), AW'(a0)};
    endtask

    // One clock: compare all outputs before the edge, then advance the model across it
    task automatic cycle();
        #1;
        chk("busy_a", {{(W-1){1'b0}}, busy_a}, (clear_left > 0) ? 32'd1 : 32'd0);
        chk("busy_b", {{(W-1){1'b0}}, busy_b}, (clear_left > 0) ? 32'd1 : 32'd0);
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("rd_a[%0d] ra=%0d", p, ra[p*AW +: AW]), rd_a[p*W +: W], exp_rd(1'b0, ra[p*AW +: AW]));
            chk($sformatf("rd_b[%0d] ra=%0d", p, ra[p*AW +: AW]), rd_b[p*W +: W], exp_rd(1'b1, ra[p*AW +: AW]));
        end
        last_busy = busy_a;
        @(posedge clk);
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (we0 && wa0 != '0) ref_mem[wa0] = wd0;
            if (we1 && wa1 != '0) ref_mem[wa1] = wd1;
            if (clr) begin
                clear_left = DEPTH;
                zero_model();
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy", {{(W-1){1'b0}}, busy_a}, 32'd1);
        clear_left = DEPTH;
        zero_model();
        @(posedge clk);
        #1;
        chk("rst_hold_busy", {{(W-1){1'b0}}, busy_b}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run until busy drops, counting busy cycles; optionally write and re-pulse clr during the walk
    task automatic run_busy(input bit noisy, output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            set_idle();
            if (noisy) begin
                we0 = (k < 25);
                wa0 = AW'($urandom);
                wd0 = $urandom;
                clr = (k == 10);
                set_ra($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            end
            cycle();
            if (!last_busy) break;
            n++;
        end
        set_idle();
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        set_idle();
        set_ra(0, 0);
        clear_left = 0;
        zero_model();
        @(negedge clk);

        // Power-up scrub
        do_reset();
        run_busy(1'b0, n);
        chk("rst_busy_len", n, 32);
        for (int i = 0; i < DEPTH; i++) begin
            set_ra(i, DEPTH - 1 - i);
            cycle();
        end

        // Plain write: old value this cycle, new value next
        we0 = 1'b1; wa0 = 5; wd0 = 32'hDEADBEEF; set_ra(5, 5);
        #1 chk("wr_old", rd_a[W-1:0], 32'h0);
        cycle();
        set_idle();
        #1 chk("wr_new", rd_a[W-1:0], 32'hDEADBEEF);
        cycle();

        // Collision: port 1 wins
        we0 = 1'b1; wa0 = 7; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 7; wd1 = 32'h22222222; set_ra(0, 7);
        cycle();
        set_idle();
        #1 chk("collide", rd_a[2*W-1:W], 32'h22222222);
        cycle();

        // Entry 0 stays zero even with a forwarded write
        we1 = 1'b1; wa1 = 0; wd1 = 32'hFFFFFFFF; set_ra(0, 0);
        #1 chk("zero_same", rd_b[W-1:0], 32'h0);
        cycle();
        set_idle();
        #1 chk("zero_after", rd_b[W-1:0], 32'h0);
        cycle();

        // Bypass forwards in the write cycle
        we0 = 1'b1; wa0 = 3; wd0 = 32'hCAFE0003; set_ra(0, 3);
        #1 chk("bypass", rd_b[2*W-1:W], 32'hCAFE0003);
        cycle();
        set_idle();

        // Random traffic with biased address collisions and rare clears
        for (int k = 0; k < 400; k++) begin
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            wa0 = AW'($urandom);
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
            wd0 = $urandom;
            wd1 = $urandom;
            clr = ($urandom_range(0, 79) == 0);
            set_ra(($urandom_range(0, 2) == 0) ? int'(wa0) : $urandom_range(0, DEPTH - 1),
                   ($urandom_range(0, 2) == 0) ? int'(wa1) : $urandom_range(0, DEPTH - 1));
            cycle();
        end
        set_idle();
        run_busy(1'b0, n);

        // Fill, clear, write and re-pulse clr during the walk
        for (int i = 1; i < DEPTH; i++) begin
            we0 = 1'b1; wa0 = AW'(i); wd0 = $urandom | 32'h1;
            cycle();
        end
        set_idle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        run_busy(1'b1, n);
        chk("clr_busy_len", n, 32);
        for (int i = 0; i < DEPTH; i++) begin
            set_ra(i, DEPTH - 1 - i);
            #1 chk($sformatf("clr_zero %0d", i), rd_a[W-1:0], 32'h0);
            cycle();
        end

        // Reset in the middle of a walk restarts it from the top
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        repeat (10) cycle();
        do_reset();
        run_busy(1'b0, n);
        chk("rst_mid_len", n, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register in bits.
REQ-002 Parameter AW, default 5, address width; DEPTH = 2**AW entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-005 Parameter BYPASS, default 0; when 1, a same-cycle write is forwarded to matching read ports.
REQ-006 One clock; reset is asynchronous and active-low: clk and rst_n.
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 we0  input  1  write enable, write port 0.
REQ-010 wa0  input  AW  write address, port 0.
REQ-011 wd0  input  WIDTH  write data, port 0.
REQ-012 we1, wa1, wd1  input  1/AW/WIDTH  write port 1, same meaning as port 0; higher priority.
REQ-013 ra  input  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-014 rd  output  NUM_RD*WIDTH  packed read data; port i occupies bits [i*WIDTH +: WIDTH].
REQ-015 clr  input  1  single-cycle request to start a clear sequence.
REQ-016 busy  output  1  high while a clear sequence runs.

Function
REQ-017 Reads SHALL be combinational: rd[i] = entry[ra[i]], zero-latency.
REQ-018 With ZERO_REG=1, rd[i] SHALL be 0 whenever ra[i]==0, independent of the array contents.
REQ-019 Writes SHALL commit on the rising edge of clk when the enable is high and busy is low.
REQ-020 If we0 and we1 target the same address in the same cycle, only wd1 SHALL be stored.
REQ-021 With ZERO_REG=1, writes to address 0 SHALL be discarded and SHALL NOT be forwarded.
REQ-022 With BYPASS=1 and busy low, rd[i] SHALL equal the write data of the highest-priority enabled port whose address equals ra[i]; otherwise the stored value.
REQ-023 With BYPASS=0, rd[i] SHALL show the old value during the write cycle and the new value from the next cycle.
REQ-024 The clear FSM SHALL have two states: IDLE (busy=0) and CLEAR (busy=1).
REQ-025 IDLE->CLEAR SHALL occur on the edge where clr=1; the clear counter SHALL load 0.
REQ-026 In CLEAR, each cycle SHALL zero entry[cnt] and increment cnt by 1.
REQ-027 CLEAR->IDLE SHALL occur on the edge that zeroes entry DEPTH-1; the sequence takes exactly DEPTH cycles.
REQ-028 clr asserted during CLEAR SHALL be ignored; the sequence SHALL NOT restart.
REQ-029 While busy=1, all writes SHALL be dropped and every rd[i] SHALL read 0.
REQ-030 The counter SHALL be AW bits wide and SHALL NOT wrap back into CLEAR.

Reset
REQ-031 rst_n low SHALL immediately force state=CLEAR, cnt=0 and busy=1, independent of clk.
REQ-032 Array contents SHALL NOT be reset directly; after rst_n rises, the clear sequence SHALL zero all entries in DEPTH cycles.
REQ-033 rst_n asserted mid-sequence SHALL restart the clear at cnt=0.

Structure
REQ-034 A shared package regfile_pkg SHALL hold the FSM state type (IDLE, CLEAR) and the default constants for WIDTH, AW and NUM_RD.
REQ-035 The FSM and counter SHALL be a sub-module regfile_clr_seq that outputs busy, the clear address and the clear strobe; the array, read muxing and bypass SHALL stay in regfile_mp.

Verification
REQ-036 Reset and auto-clear: release rst_n with defaults -> busy=1 for exactly 32 cycles, then 0; all 32 entries read 0.
REQ-037 Write/read: we0=1, wa0=5, wd0=0xDEADBEEF, BYPASS=0 -> rd[0] (ra=5) shows the old value that cycle and 0xDEADBEEF the next.
REQ-038 Write collision: we0 and we1 both target address 7 with 0x11111111 and 0x22222222 -> entry 7 reads 0x22222222.
REQ-039 Zero register: we1=1, wa1=0, wd1=0xFFFFFFFF with BYPASS=1 -> rd for ra=0 reads 0 that cycle and afterwards.
REQ-040 Bypass: BYPASS=1, we0 to address 3 with 0xCAFE0003 and ra[1]=3 -> rd[1]=0xCAFE0003 in the same cycle.
REQ-041 Clear and busy: fill entries 1..31, pulse clr, write during busy and pulse clr again at cycle 10 -> busy lasts exactly 32 cycles, the write is lost and all entries read 0.
